keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 active-low matrix keypad on the board I/O bank and delivers debounced key codes to the processor's memory-mapped input port. It is the input-side counterpart of the multiplexed seven-segment display driver. It uses the same divided-clock column rotation (1110→1101→1011→0111), but drives columns and reads rows instead of driving anodes and segments. One key event is produced per physical press, held under a valid/ack handshake.

## Interface
- SCAN_DIV, 100_000, clk cycles per column step; must be ≥ 4.
- DEBOUNCE_SCANS, 4, consecutive full frames a key state must persist; must be 1..15.
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- rows  input  4  matrix rows; active-low, externally pulled up; asynchronous to clk.
- cols  output  4  column drive; active-low one-hot-zero.
- key_code  output  4  code of last accepted key, {row_idx[1:0], col_idx[1:0]}.
- key_valid  output  1  a new key is pending.
- key_ack  input  1  consumer takes the pending key.
- overrun  output  1  sticky flag: a key arrived while one was still pending.
- history  output  16  only with KEYPAD_HISTORY_EN (see Configuration).

## Operation
- Reset values:
  - cols=4'b1110, key_code=0, key_valid=0, overrun=0, history=0.
  - State IDLE; all counters 0.
- Synchronization: rows passes through a 2-flop synchronizer before any use.
- Column stepping:
  - Divider counts 0..SCAN_DIV-1.
  - On the terminal count (the "tick"), the synchronized rows are captured into the frame image slot of the currently driven column. Then cols rotates.
  - col_idx: 0 for 1110, 1 for 1101, 2 for 1011, 3 for 0111.
- Frame evaluation:
  - After the tick that captures column 3, the 16-bit image is classified as NONE (all released), SINGLE (exactly one low bit, code = row_idx*4+col_idx) or MULTI (two or more low bits).
  - row_idx is the row bit position.
- FSM, advancing once per frame:
  - IDLE: SINGLE → DEBOUNCE (cnt=1, cand=code). NONE or MULTI → stay.
  - DEBOUNCE:
    - SINGLE with the same cand: cnt+1. When cnt reaches DEBOUNCE_SCANS, accept and go to PRESSED.
    - Any other classification → IDLE.
    - If DEBOUNCE_SCANS=1, accept on entry: IDLE goes directly to PRESSED.
  - PRESSED:
    - NONE: cnt+1. Reaching DEBOUNCE_SCANS → IDLE.
    - SINGLE or MULTI: cnt=0, stay. A held key or an added key generates no new event.
- Accept:
  - key_code←cand and key_valid←1.
  - If key_valid was already 1 and key_ack is not asserted that cycle, overrun←1.
- Handshake:
  - key_ack while key_valid=1 clears key_valid and overrun on the next edge.
  - key_ack while key_valid=0 is ignored.
  - Accept and key_ack in the same cycle: the accept wins (key_valid stays 1, new code) and overrun is cleared.
- Reset mid-press: the scanner returns to IDLE. A key still held re-debounces and produces a fresh event.

## Timing
- Each column is driven for SCAN_DIV cycles. The rows sample is taken at the end of that column's window, after the synchronizer has had SCAN_DIV-2 cycles of settle.
- A frame lasts 4·SCAN_DIV cycles.
- Press-to-key_valid latency: between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 frames, plus 3 cycles. key_valid is registered and rises one cycle after the final frame tick.
- Release must persist DEBOUNCE_SCANS frames before the next press can be accepted.
- key_code is stable whenever key_valid=1 and only changes on an accept.

## Configuration
- KEYPAD_HISTORY_EN defined:
  - The history[15:0] port exists.
  - On each accept, history←{history[11:0], new key_code}. Reset value is 0.
  - The port connects directly to the display driver's 16-bit input, so the last four keys are shown as hex digits.
- Undefined: the history port and register are absent; all other behaviour is identical.

## Structure
- Package keypad_pkg:
  - FSM state enum (IDLE, DEBOUNCE, PRESSED).
  - Column pattern constants COL0..COL3.
  - Key code width constant.
- One sub-module, scan_timer: the SCAN_DIV divider, producing a single-cycle tick and the 2-bit column index.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2, with a matrix model that pulls rows low when the pressed key's column is driven low.
- Hold key row 2 / col 1 for 5 frames → one key_valid with key_code=4'h9; no second event while held.
- Press row 0 / col 0, ack, release 2 frames, press row 3 / col 3 → codes 0 then F, each valid exactly once.
- Key bounces (toggles every frame) for 6 frames, then is held stable → key_valid=0 during bounce; asserts only after 2 stable frames.
- Two keys pressed simultaneously from IDLE → no event. Hold key 5 then add key 6 → only code 5 reported.
- Two presses with no ack → key_valid=1, key_code=second code, overrun=1. key_ack → both cleared next cycle.
- rst_n pulsed low mid-DEBOUNCE with the key held → outputs return to reset values immediately and cols=1110. After release of reset, one event is produced. With KEYPAD_HISTORY_EN, keys 1,2,3,4 give history=16'h1234.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg -- shared types and constants for the 4x4 keypad scanner.
//
// Contents:
//   state_t      debounce FSM states (IDLE, DEBOUNCE, PRESSED)
//   frame_cls_t  classification of one full 16-bit frame image
//   COL0..COL3   active-low column drive patterns, one per column index
//   KEY_W        width of a key code {row_idx[1:0], col_idx[1:0]}
//   col_pattern  maps a column index to its drive pattern
package keypad_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } frame_cls_t;

  // One column pulled low at a time; index 0 is the rightmost bit.
  localparam logic [3:0] COL0 = 4'b1110;
  localparam logic [3:0] COL1 = 4'b1101;
  localparam logic [3:0] COL2 = 4'b1011;
  localparam logic [3:0] COL3 = 4'b0111;

  function automatic logic [3:0] col_pattern(input logic [1:0] idx);
    logic [3:0] pat;
    case (idx)
      2'd0:    pat = COL0;
      2'd1:    pat = COL1;
      2'd2:    pat = COL2;
      default: pat = COL3;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/keypad_scanner_scan_timer.sv
// scan_timer -- column-step divider for the keypad scanner.
//
// Counts 0..SCAN_DIV-1 and raises tick for one cycle on the terminal
// count. col_idx is the column currently being driven; it advances on the
// same edge that ends the tick cycle, so during a tick col_idx still names
// the column whose window is closing.
//
// Ports:
//   clk      system clock, posedge
//   rst_n    asynchronous active-low reset
//   tick     single-cycle pulse at the end of each column window
//   col_idx  index (0..3) of the column being driven
//
// SCAN_DIV must be at least 4 so the row synchronizer has time to settle
// inside each column window.
module scan_timer #(
  parameter int SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tick,
  output logic [1:0] col_idx
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] div_cnt;

  // Decoded from a register, so the pulse is clean for synchronous users.
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
    end else if (tick) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner -- scans a 4x4 active-low matrix keypad and delivers one
// debounced key code per physical press under a valid/ack handshake.
//
// Ports:
//   clk        system clock, posedge
//   rst_n      asynchronous active-low reset
//   rows[3:0]  matrix rows, active-low, pulled up, asynchronous to clk
//   cols[3:0]  column drive, active-low, one column low at a time
//   key_code   last accepted key, {row_idx[1:0], col_idx[1:0]}
//   key_valid  a new key is pending
//   key_ack    consumer takes the pending key
//   overrun    sticky: a key was accepted while the previous was pending
//   history    (KEYPAD_HISTORY_EN only) last four accepted codes, newest in
//              the low nibble
//
// Handshake: key_valid rises on an accept and holds, with key_code stable,
// until a cycle where key_ack=1 and key_valid=1; the pending key is then
// consumed on that edge. key_ack while key_valid=0 has no effect. An accept
// in the same cycle as a consuming ack wins: key_valid stays high with the
// new code, and overrun is cleared because the old key was taken.
//
// Build option: define KEYPAD_HISTORY_EN to add the history register/port.
//
// The debounce FSM state is visible for checkers as the internal signal
// `state` (type state_t).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100_000,  // clk cycles per column, >= 4
  parameter int DEBOUNCE_SCANS = 4         // frames a state must persist, 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       rows,
  output logic [3:0]       cols,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ack,
  output logic             overrun
`ifdef KEYPAD_HISTORY_EN
  ,
  output logic [15:0]      history
`endif
);

  localparam logic [3:0] DS_N = 4'(DEBOUNCE_SCANS);

  // --------------------------------------------------------------------
  // Column timing
  // --------------------------------------------------------------------
  logic       tick;
  logic [1:0] col_idx;
  logic [1:0] next_col;

  scan_timer #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .col_idx(col_idx)
  );

  assign next_col = col_idx + 2'd1;

  // --------------------------------------------------------------------
  // Row synchronizer and frame image
  // --------------------------------------------------------------------
  // Synchronizer resets to "all released" so reset never looks like a press.
  logic [3:0]  rows_meta;
  logic [3:0]  rows_sync;
  // image[{c, r}] holds row r as seen while column c was driven (0 = pressed).
  logic [15:0] image;
  // One-cycle pulse the cycle after column 3 was captured: image is complete.
  logic        frame_eval;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_meta  <= 4'hF;
      rows_sync  <= 4'hF;
      image      <= 16'hFFFF;
      cols       <= COL0;
      frame_eval <= 1'b0;
    end else begin
      rows_meta  <= rows;
      rows_sync  <= rows_meta;
      frame_eval <= tick && (col_idx == 2'd3);
      if (tick) begin
        // Sample at the end of the window, then move to the next column.
        image[{col_idx, 2'b00} +: 4] <= rows_sync;
        cols                         <= col_pattern(next_col);
      end
    end
  end

  // --------------------------------------------------------------------
  // Frame classification
  // --------------------------------------------------------------------
  logic [4:0]       low_cnt;
  logic [KEY_W-1:0] low_code;
  frame_cls_t       cls;

  always_comb begin
    low_cnt  = 5'd0;
    low_code = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!image[c*4 + r]) begin
          low_cnt  = low_cnt + 5'd1;
          low_code = {2'(r), 2'(c)};
        end
      end
    end
    if (low_cnt == 5'd0) begin
      cls = CLS_NONE;
    end else if (low_cnt == 5'd1) begin
      cls = CLS_SINGLE;
    end else begin
      cls = CLS_MULTI;
    end
  end

  // --------------------------------------------------------------------
  // Debounce FSM
  // --------------------------------------------------------------------
  state_t           state;
  logic [3:0]       cnt;   // stable frames (DEBOUNCE) or released frames (PRESSED)
  logic [3:0]       cnt_inc;
  logic [KEY_W-1:0] cand;
  logic             accept;

  assign cnt_inc = cnt + 4'd1;

  // An accept is the frame that completes the debounce run. With
  // DEBOUNCE_SCANS=1 the very first SINGLE frame from IDLE qualifies.
  always_comb begin
    accept = 1'b0;
    if (frame_eval) begin
      case (state)
        IDLE:     accept = (cls == CLS_SINGLE) && (DS_N == 4'd1);
        DEBOUNCE: accept = (cls == CLS_SINGLE) && (low_code == cand) &&
                           (cnt_inc == DS_N);
        default:  accept = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      cand  <= '0;
    end else if (frame_eval) begin
      case (state)
        IDLE: begin
          if (cls == CLS_SINGLE) begin
            cand <= low_code;
            if (DS_N == 4'd1) begin
              state <= PRESSED;
              cnt   <= 4'd0;
            end else begin
              state <= DEBOUNCE;
              cnt   <= 4'd1;
            end
          end
        end
        DEBOUNCE: begin
          if ((cls == CLS_SINGLE) && (low_code == cand)) begin
            if (cnt_inc == DS_N) begin
              state <= PRESSED;
              cnt   <= 4'd0;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            // Bounce, different key or chord: start over from scratch.
            state <= IDLE;
            cnt   <= 4'd0;
          end
        end
        PRESSED: begin
          // Only an unbroken run of released frames re-arms the scanner;
          // a held or added key restarts the release count.
          if (cls == CLS_NONE) begin
            if (cnt_inc == DS_N) begin
              state <= IDLE;
              cnt   <= 4'd0;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            cnt <= 4'd0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------
  // Output handshake
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (accept) begin
      key_code  <= low_code;
      key_valid <= 1'b1;
      if (key_valid && !key_ack) begin
        overrun <= 1'b1;
      end else if (key_valid && key_ack) begin
        overrun <= 1'b0;
      end
    end else if (key_valid && key_ack) begin
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

`ifdef KEYPAD_HISTORY_EN
  // Shift register of accepted codes for the hex display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history <= 16'h0000;
    end else if (accept) begin
      history <= {history[11:0], low_code};
    end
  end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner -- self-checking bench for keypad_scanner with
// SCAN_DIV=4 and DEBOUNCE_SCANS=2. A matrix model pulls a row low while a
// pressed key's column is driven. Key patterns change only at frame
// boundaries, and a frame-level reference model predicts each key event and
// the exact cycle key_valid should appear.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DS       = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  // ------------------------------------------------------------------
  // Clock / reset / DUT
  // ------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack = 1'b0;
  logic        overrun;
`ifdef KEYPAD_HISTORY_EN
  logic [15:0] history;
`endif

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rows     (rows),
    .cols     (cols),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ack  (key_ack),
    .overrun  (overrun)
`ifdef KEYPAD_HISTORY_EN
    ,
    .history  (history)
`endif
  );

  // Matrix model: bit r*4+c of pressed is the key at row r, column c.
  logic [15:0] pressed = 16'h0000;

  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4 + c] && !cols[c]) rows[r] = 1'b0;
      end
    end
  end

  // Cycle count since reset release: edge k after release gives cyc=k.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ------------------------------------------------------------------
  // Scoreboard state and checking helpers
  // ------------------------------------------------------------------
  logic [3:0] exp_q[$];
  int         exp_t[$];
  int         errors = 0;
  int         checks = 0;
  bit         sb_en = 1'b0;
  bit         man_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model, one call per frame of constant key pattern
  // ------------------------------------------------------------------
  bit          m_armed;    // ready to accept a new press
  int          m_run_code; // key of the current stable single-key run
  int          m_run_len;  // frames in that run
  int          m_rel;      // consecutive released frames after an event
  logic [15:0] m_hist;
  int          fidx;       // frame number since reset release

  task automatic model_reset();
    m_armed    = 1'b1;
    m_run_code = 0;
    m_run_len  = 0;
    m_rel      = 0;
    m_hist     = 16'h0000;
    fidx       = 0;
  endtask

  // -1 released, -2 two or more keys, otherwise the key code.
  function automatic int classify(input logic [15:0] k);
    int res;
    res = -1;
    if ($countones(k) > 1) begin
      res = -2;
    end else begin
      for (int i = 0; i < 16; i++) if (k[i]) res = i;
    end
    return res;
  endfunction

  task automatic model_frame(input logic [15:0] k);
    int x;
    x = classify(k);
    if (!m_armed) begin
      // After an event, only DS released frames in a row re-arm.
      if (x == -1) begin
        m_rel++;
        if (m_rel == DS) begin
          m_armed   = 1'b1;
          m_run_len = 0;
        end
      end else begin
        m_rel = 0;
      end
    end else begin
      // A run must begin from a clean slate; a frame that breaks a run is
      // discarded rather than starting a new one.
      if (x >= 0 && (m_run_len == 0 || x == m_run_code)) begin
        m_run_code = x;
        m_run_len++;
      end else begin
        m_run_len = 0;
      end
      if (m_run_len == DS) begin
        m_armed   = 1'b0;
        m_rel     = 0;
        m_run_len = 0;
        m_hist    = {m_hist[11:0], 4'(m_run_code)};
        if (sb_en) begin
          exp_q.push_back(4'(m_run_code));
          // Last column of frame fidx captured at edge FRAME*(fidx+1);
          // key_valid is registered one edge later.
          exp_t.push_back(FRAME * (fidx + 1) + 1);
        end
      end
    end
  endtask

  // ------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at a negedge)
  // ------------------------------------------------------------------
  task automatic run_frame(input logic [15:0] k);
    pressed = k;
    model_frame(k);
    repeat (FRAME) @(posedge clk);
    @(negedge clk);
    fidx++;
  endtask

  task automatic run_key(input int code, input int n);
    repeat (n) run_frame(16'(1) << code);
  endtask

  task automatic release_frames(input int n);
    repeat (n) run_frame(16'h0000);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cols"}, cols, 4'b1110);
    check({tag, "_key_code"}, key_code, 4'h0);
    check({tag, "_key_valid"}, key_valid, 1'b0);
    check({tag, "_overrun"}, overrun, 1'b0);
`ifdef KEYPAD_HISTORY_EN
    check({tag, "_history"}, history, 16'h0000);
`endif
  endtask

  // ------------------------------------------------------------------
  // Monitor: pops one expected key per presented key, then acks it
  // ------------------------------------------------------------------
  initial begin : monitor
    logic [3:0] e;
    int         t;
    forever begin
      @(negedge clk);
      if (!sb_en) begin
        key_ack = man_ack;
      end else if (key_ack) begin
        key_ack = 1'b0;
      end else if (rst_n && key_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key: got code %0h, expected no event (cyc=%0d)",
                   key_code, cyc);
        end else begin
          e = exp_q.pop_front();
          t = exp_t.pop_front();
          check("key_code", key_code, e);
          check("valid_cycle", cyc, t);
          check("overrun_clear", overrun, 1'b0);
        end
        key_ack = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  initial begin : stim
    int sel;
    logic [15:0] cur;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");

    rst_n = 1'b1;
    sb_en = 1'b1;

    // Held key 9: one event only.
    run_key(9, 5);
    release_frames(2);
    // Code 0, release, code F.
    run_key(0, 3);
    release_frames(2);
    run_key(15, 3);
    release_frames(2);
    // Bounce every frame, then stable.
    for (int i = 0; i < 6; i++) run_frame((i % 2 == 0) ? 16'h0080 : 16'h0000);
    run_key(7, 3);
    release_frames(2);
    // Chord from idle: no event.
    repeat (3) run_frame(16'h0C00);
    release_frames(2);
    // Key 5 held, then key 6 added: only 5.
    run_key(5, 2);
    repeat (2) run_frame(16'h0060);
    release_frames(2);
    drain("directed_drain");

    // Randomized key sequences.
    cur = 16'h0000;
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      if (sel >= 5 && sel <= 6) cur = 16'h0000;
      else if (sel >= 7 && sel <= 8) cur = 16'(1) << $urandom_range(0, 15);
      else if (sel == 9) cur = (16'(1) << $urandom_range(0, 15)) |
                               (16'(1) << $urandom_range(0, 15));
      run_frame(cur);
    end
    release_frames(3);
    drain("random_drain");
`ifdef KEYPAD_HISTORY_EN
    check("random_history", history, m_hist);
`endif

    // Two presses with no ack: overrun.
    sb_en = 1'b0;
    run_key(1, 3);
    release_frames(2);
    run_key(2, 3);
    release_frames(2);
    check("ovr_valid", key_valid, 1'b1);
    check("ovr_code", key_code, 4'h2);
    check("ovr_flag", overrun, 1'b1);
    @(posedge clk);
    man_ack = 1'b1;
    @(posedge clk);
    man_ack = 1'b0;
    @(negedge clk);
    #1;
    check("ack_valid", key_valid, 1'b0);
    check("ack_overrun", overrun, 1'b0);

    // Leave a key pending, then reset mid-debounce with a key held.
    @(negedge clk);
    run_key(6, 2);
    release_frames(2);
    check("pending_before_reset", key_valid, 1'b1);
    run_key(3, 1);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    repeat (3) @(negedge clk);
    model_reset();
    sb_en = 1'b1;
    rst_n = 1'b1;
    run_key(3, 3);
    release_frames(2);
    for (int k = 1; k <= 4; k++) begin
      run_key(k, 2);
      release_frames(2);
    end
    drain("post_reset_drain");
`ifdef KEYPAD_HISTORY_EN
    check("history_1234", history, 16'h1234);
    check("history_model", history, m_hist);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "time limit");
  end

endmodule
